// File: rtl/mux_sel_arbiter_if.sv
// Bus between the two requesters and the mux select arbiter.
// The master side holds the requests; the slave side (the arbiter) drives
// the mux select, both grants and the busy flag.
interface mux_sel_arbiter_if;
   logic req0;
   logic req1;
   logic sel;
   logic gnt0;
   logic gnt1;
   logic busy;

   modport master (
      output req0,
      output req1,
      input  sel,
      input  gnt0,
      input  gnt1,
      input  busy
   );

   modport slave (
      input  req0,
      input  req1,
      output sel,
      output gnt0,
      output gnt1,
      output busy
   );
endinterface : mux_sel_arbiter_if

// File: rtl/mux_sel_arbiter.sv
// Round-robin arbiter for the transmission-gate 2-to-1 mux.
// A change of the mux select is followed by SETTLE quiet cycles before the
// new owner is granted, so neither requester ever sees the mux output while
// its transmission gates are still switching. An owner is preempted after
// MAX_HOLD grant cycles, but only when the other requester is waiting.
module mux_sel_arbiter #(
   parameter int unsigned SETTLE   = 2,  // 1..255
   parameter int unsigned MAX_HOLD = 8   // 2..255
) (
   input  logic               clock,
   input  logic               reset,
   mux_sel_arbiter_if.slave   bus
);

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_SETTLE,
      ST_GRANT
   } state_e;

   localparam logic [7:0] SETTLE_LAST = 8'(SETTLE - 1);
   localparam logic [7:0] HOLD_LAST   = 8'(MAX_HOLD - 1);

   state_e     state_q;
   logic       sel_q;
   logic       gnt0_q;
   logic       gnt1_q;
   logic       busy_q;
   logic       last_q;     // id of the requester granted most recently
   logic [7:0] cnt_q;      // settle counter in ST_SETTLE, hold counter in ST_GRANT

   logic       any_req_d;
   logic       win_d;      // arbitration winner, meaningful only when any_req_d
   logic       owner_req_d;
   logic       other_req_d;

   // Arbitration and request lookup relative to the current select.
   // The target of a settle and the owner of a grant both equal sel_q,
   // so no separate owner register is needed.
   always_comb begin
      // NOTE: every signal gets a default first so no path leaves it unassigned (no latch).
      any_req_d   = bus.req0 | bus.req1;
      win_d       = 1'b0;
      owner_req_d = sel_q ? bus.req1 : bus.req0;
      other_req_d = sel_q ? bus.req0 : bus.req1;

      if (bus.req0 && bus.req1) begin
         win_d = ~last_q;
      end else if (bus.req1) begin
         win_d = 1'b1;
      end
   end

   // Arbiter FSM with registered select, grants and busy.
   always_ff @(posedge clock) begin
      // NOTE: sequential state uses non-blocking assignments only, so every register
      // samples the pre-edge values regardless of statement order.
      if (reset) begin
         state_q <= ST_IDLE;
         sel_q   <= 1'b0;
         gnt0_q  <= 1'b0;
         gnt1_q  <= 1'b0;
         busy_q  <= 1'b0;
         last_q  <= 1'b1;
         cnt_q   <= 8'd0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (any_req_d) begin
                  cnt_q  <= 8'd0;
                  busy_q <= 1'b1;
                  if (win_d == sel_q) begin
                     // Mux already points at the winner: grant at once.
                     state_q <= ST_GRANT;
                     gnt0_q  <= ~win_d;
                     gnt1_q  <= win_d;
                     last_q  <= win_d;
                  end else begin
                     // Switch the mux first; grants stay low while it settles.
                     state_q <= ST_SETTLE;
                     sel_q   <= win_d;
                  end
               end
            end

            ST_SETTLE: begin
               if (!owner_req_d) begin
                  // Target gave up: keep the new select, do not touch last.
                  state_q <= ST_IDLE;
                  busy_q  <= 1'b0;
                  cnt_q   <= 8'd0;
               end else if (cnt_q == SETTLE_LAST) begin
                  state_q <= ST_GRANT;
                  gnt0_q  <= ~sel_q;
                  gnt1_q  <= sel_q;
                  last_q  <= sel_q;
                  cnt_q   <= 8'd0;
               end else begin
                  cnt_q <= cnt_q + 8'd1;
               end
            end

            ST_GRANT: begin
               if (!owner_req_d || (cnt_q == HOLD_LAST && other_req_d)) begin
                  // Release or preemption: one dead IDLE cycle follows.
                  state_q <= ST_IDLE;
                  gnt0_q  <= 1'b0;
                  gnt1_q  <= 1'b0;
                  busy_q  <= 1'b0;
                  cnt_q   <= 8'd0;
               end else if (cnt_q != HOLD_LAST) begin
                  // Saturate so an uncontested owner can hold indefinitely.
                  cnt_q <= cnt_q + 8'd1;
               end
            end

            default: begin
               state_q <= ST_IDLE;
               gnt0_q  <= 1'b0;
               gnt1_q  <= 1'b0;
               busy_q  <= 1'b0;
               cnt_q   <= 8'd0;
            end
         endcase
      end
   end

   assign bus.sel  = sel_q;
   assign bus.gnt0 = gnt0_q;
   assign bus.gnt1 = gnt1_q;
   assign bus.busy = busy_q;

   // Safety invariants of the shared mux.
   a_onehot_gnt : assert property (@(posedge clock) disable iff (reset)
      !(gnt0_q && gnt1_q));
   a_gnt0_sel   : assert property (@(posedge clock) disable iff (reset)
      gnt0_q |-> !sel_q);
   a_gnt1_sel   : assert property (@(posedge clock) disable iff (reset)
      gnt1_q |-> sel_q);

endmodule : mux_sel_arbiter

// File: tb/tb_mux_sel_arbiter.sv
// Directed bench for mux_sel_arbiter with SETTLE=2, MAX_HOLD=8.
// Every check compares {sel, gnt0, gnt1, busy} one time unit after a
// rising edge against a hand-derived constant.
module tb_mux_sel_arbiter;

   logic clock = 1'b0;
   logic reset = 1'b1;
   int   n_checks = 0;
   int   n_fail   = 0;

   mux_sel_arbiter_if bus ();

   mux_sel_arbiter #(
      .SETTLE   (2),
      .MAX_HOLD (8)
   ) dut (
      .clock (clock),
      .reset (reset),
      .bus   (bus.slave)
   );

   always #5 clock = ~clock;

   // Advance n rising edges, ending just after the last one.
   task automatic tick(input int n = 1);
      for (int i = 0; i < n; i++) begin
         @(posedge clock);
         #1;
      end
   endtask

   // Compare {sel, gnt0, gnt1, busy} against the expected pattern.
   task automatic check(input string tag, input logic [3:0] exp);
      logic [3:0] obs;
      obs = {bus.sel, bus.gnt0, bus.gnt1, bus.busy};
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed sel/g0/g1/busy=%b expected %b", tag, obs, exp);
      end
   endtask

   initial begin
      bus.req0 = 1'b0;
      bus.req1 = 1'b0;

      // Reset state.
      tick();
      check("reset", 4'b0000);
      reset = 1'b0;
      tick();
      check("idle_no_req", 4'b0000);

      // Same-select grant to requester 0, then release.
      bus.req0 = 1'b1;
      tick();
      check("g0_same_sel", 4'b0101);
      tick(2);
      check("g0_hold", 4'b0101);
      bus.req0 = 1'b0;
      tick();
      check("g0_release", 4'b0000);

      // Select-change grant to requester 1: two settle cycles.
      bus.req1 = 1'b1;
      tick();
      check("g1_settle0", 4'b1001);
      tick();
      check("g1_settle1", 4'b1001);
      tick();
      check("g1_granted", 4'b1011);

      // Uncontested owner keeps the grant; counter saturates silently.
      for (int i = 0; i < 20; i++) begin
         tick();
         check("g1_uncontested", 4'b1011);
      end

      // Contender arrives with the hold counter saturated: immediate preemption.
      bus.req0 = 1'b1;
      tick();
      check("g1_preempted", 4'b1000);
      tick();
      check("g0_settle0", 4'b0001);
      tick();
      check("g0_settle1", 4'b0001);

      // Both held: 8 grant cycles, 1 idle, 2 settle, then the other side.
      for (int i = 0; i < 8; i++) begin
         tick();
         check("rr_g0", 4'b0101);
      end
      tick();
      check("rr_idle_a", 4'b0000);
      tick();
      check("rr_settle_a0", 4'b1001);
      tick();
      check("rr_settle_a1", 4'b1001);
      for (int i = 0; i < 8; i++) begin
         tick();
         check("rr_g1", 4'b1011);
      end
      tick();
      check("rr_idle_b", 4'b1000);
      tick();
      check("rr_settle_b0", 4'b0001);

      // Both drop mid-settle: back to idle, select stays at 0.
      bus.req0 = 1'b0;
      bus.req1 = 1'b0;
      tick();
      check("abort_settle_sel0", 4'b0000);

      // Requester 1 from sel=0, dropped during settle: sel stays 1.
      bus.req1 = 1'b1;
      tick();
      check("abort_start", 4'b1001);
      bus.req1 = 1'b0;
      tick();
      check("abort_idle", 4'b1000);
      tick();
      check("abort_stay", 4'b1000);

      // Requester 0 now needs a settle window because sel is 1.
      bus.req0 = 1'b1;
      tick();
      check("after_abort_settle0", 4'b0001);
      tick();
      check("after_abort_settle1", 4'b0001);
      tick();
      check("after_abort_g0", 4'b0101);
      bus.req0 = 1'b0;
      tick();
      check("after_abort_rel", 4'b0000);

      // Reset while requester 1 owns the mux with sel=1.
      bus.req1 = 1'b1;
      tick(3);
      check("pre_reset_g1", 4'b1011);
      reset = 1'b1;
      tick();
      check("reset_mid_grant", 4'b0000);

      // After reset last=1, so requester 0 wins a tie and sel=0 needs no settle.
      reset = 1'b0;
      bus.req0 = 1'b1;
      tick();
      check("post_reset_tie_g0", 4'b0101);

      // Reset mid-settle: sel returns to 0.
      bus.req0 = 1'b0;
      tick();
      check("post_reset_rel", 4'b0000);
      tick();
      check("settle_before_reset", 4'b1001);
      reset = 1'b1;
      tick();
      check("reset_mid_settle", 4'b0000);
      reset = 1'b0;
      bus.req1 = 1'b0;

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule : tb_mux_sel_arbiter
